// File: rtl/pinger_localizer.sv
// Weighted-centroid pinger localizer: serial accumulate over channels,
// then three parallel restoring dividers produce fixed-point x/y/z.
module pinger_localizer #(
    parameter int N  = 4,
    parameter int DW = 12,
    parameter int PW = 8,
    parameter int FB = 4,
    localparam int QW = PW + FB
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N*DW-1:0]   in_weight,
    input  logic [N*3*PW-1:0] in_pos,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [QW-1:0]     out_x,
    output logic [QW-1:0]     out_y,
    output logic [QW-1:0]     out_z,
    output logic              out_err,
    output logic              busy
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int SW = DW + PW + CW;
    localparam int WW = DW + CW;
    localparam int NW = WW + QW;
    localparam int BW = $clog2(QW + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DIVIDE,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [N*DW-1:0]     w_q, w_d;
    logic [N*3*PW-1:0]   pos_q, pos_d;
    logic [CW-1:0]       idx_q, idx_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [SW-1:0]       sx_q, sx_d, sy_q, sy_d, sz_q, sz_d;
    logic [WW-1:0]       sw_q, sw_d;
    logic [NW-1:0]       rx_q, rx_d, ry_q, ry_d, rz_q, rz_d;
    logic [NW-1:0]       dsh_q, dsh_d;
    logic [QW-1:0]       qx_q, qx_d, qy_q, qy_d, qz_q, qz_d;
    logic                err_q, err_d;

    logic [DW-1:0]       wsel;
    logic [PW-1:0]       xsel, ysel, zsel;
    logic [DW+PW-1:0]    px, py, pz;
    logic [SW-1:0]       sx_add, sy_add, sz_add;
    logic [WW-1:0]       sw_add;
    logic                gx, gy, gz;

    // Current channel operands and running sums including that channel
    always_comb begin
        wsel = '0;
        xsel = '0;
        ysel = '0;
        zsel = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(idx_q) == i) begin
                wsel = w_q[i*DW +: DW];
                xsel = pos_q[(3*i)*PW +: PW];
                ysel = pos_q[(3*i+1)*PW +: PW];
                zsel = pos_q[(3*i+2)*PW +: PW];
            end
        end
        px = {{PW{1'b0}}, wsel} * {{DW{1'b0}}, xsel};
        py = {{PW{1'b0}}, wsel} * {{DW{1'b0}}, ysel};
        pz = {{PW{1'b0}}, wsel} * {{DW{1'b0}}, zsel};
        sx_add = sx_q + {{CW{1'b0}}, px};
        sy_add = sy_q + {{CW{1'b0}}, py};
        sz_add = sz_q + {{CW{1'b0}}, pz};
        sw_add = sw_q + {{CW{1'b0}}, wsel};
        gx = (rx_q >= dsh_q);
        gy = (ry_q >= dsh_q);
        gz = (rz_q >= dsh_q);
    end

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        pos_d   = pos_q;
        idx_d   = idx_q;
        bit_d   = bit_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        sz_d    = sz_q;
        sw_d    = sw_q;
        rx_d    = rx_q;
        ry_d    = ry_q;
        rz_d    = rz_q;
        dsh_d   = dsh_q;
        qx_d    = qx_q;
        qy_d    = qy_q;
        qz_d    = qz_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = ACCUM;
                    w_d     = in_weight;
                    pos_d   = in_pos;
                    idx_d   = '0;
                    sx_d    = '0;
                    sy_d    = '0;
                    sz_d    = '0;
                    sw_d    = '0;
                    qx_d    = '0;
                    qy_d    = '0;
                    qz_d    = '0;
                    err_d   = 1'b0;
                end
            end
            ACCUM: begin
                sx_d  = sx_add;
                sy_d  = sy_add;
                sz_d  = sz_add;
                sw_d  = sw_add;
                idx_d = idx_q + CW'(1);
                if (idx_q == CW'(N - 1)) begin
                    idx_d = '0;
                    if (sw_add == '0) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = DIVIDE;
                        rx_d    = NW'(sx_add) << FB;
                        ry_d    = NW'(sy_add) << FB;
                        rz_d    = NW'(sz_add) << FB;
                        // Quotient fits in QW bits, so start at bit QW-1
                        dsh_d   = NW'(sw_add) << (QW - 1);
                        bit_d   = BW'(QW - 1);
                    end
                end
            end
            DIVIDE: begin
                rx_d  = gx ? rx_q - dsh_q : rx_q;
                ry_d  = gy ? ry_q - dsh_q : ry_q;
                rz_d  = gz ? rz_q - dsh_q : rz_q;
                qx_d  = {qx_q[QW-2:0], gx};
                qy_d  = {qy_q[QW-2:0], gy};
                qz_d  = {qz_q[QW-2:0], gz};
                dsh_d = dsh_q >> 1;
                bit_d = bit_q - BW'(1);
                if (bit_q == '0) begin
                    state_d = DONE;
                    bit_d   = '0;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            w_q     <= '0;
            pos_q   <= '0;
            idx_q   <= '0;
            bit_q   <= '0;
            sx_q    <= '0;
            sy_q    <= '0;
            sz_q    <= '0;
            sw_q    <= '0;
            rx_q    <= '0;
            ry_q    <= '0;
            rz_q    <= '0;
            dsh_q   <= '0;
            qx_q    <= '0;
            qy_q    <= '0;
            qz_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            pos_q   <= pos_d;
            idx_q   <= idx_d;
            bit_q   <= bit_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            sz_q    <= sz_d;
            sw_q    <= sw_d;
            rx_q    <= rx_d;
            ry_q    <= ry_d;
            rz_q    <= rz_d;
            dsh_q   <= dsh_d;
            qx_q    <= qx_d;
            qy_q    <= qy_d;
            qz_q    <= qz_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign out_x     = qx_q;
    assign out_y     = qy_q;
    assign out_z     = qz_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_pinger_localizer.sv
// Directed table-driven bench for pinger_localizer (N=3, DW=8, PW=3, FB=4).
module tb_pinger_localizer;

    localparam int N  = 3;
    localparam int DW = 8;
    localparam int PW = 3;
    localparam int FB = 4;
    localparam int QW = PW + FB;
    localparam int LAT_OK  = N + QW + 1;
    localparam int LAT_ERR = N + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [N*DW-1:0]   in_weight = '0;
    logic [N*3*PW-1:0] in_pos = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [QW-1:0]     out_x, out_y, out_z;
    logic              out_err;
    logic              busy;

    pinger_localizer #(.N(N), .DW(DW), .PW(PW), .FB(FB)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_weight(in_weight), .in_pos(in_pos),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_z(out_z),
        .out_err(out_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  w0, w1, w2;
        logic [26:0] pos;
        int          ex, ey, ez;
        int          eerr;
        int          lat;
    } vec_t;

    // h0=(0,0,0) h1=(1,0,0) h2=(0,1,0); fields packed {z,y,x} per hydrophone
    localparam logic [26:0] P_STD  = {3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd1, 9'd0};
    localparam logic [26:0] P_FULL = 27'h7FF_FFFF;

    int   checks = 0;
    int   errors = 0;
    int   deliveries = 0;
    int   spurious = 0;
    logic watch = 1'b0;
    vec_t tbl[8];

    always @(posedge clk) begin
        if (out_valid && out_ready) deliveries++;
        if (watch && out_valid) spurious++;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, act, act, exp, exp);
        end
    endtask

    task automatic start(input vec_t v);
        @(negedge clk);
        in_weight = {v.w2, v.w1, v.w0};
        in_pos    = v.pos;
        in_valid  = 1'b1;
        check("in_ready_before_transfer", int'(in_ready), 1);
        @(posedge clk);
    endtask

    task automatic wait_result(input string name, input int exp_lat);
        int lat;
        lat = 1;
        #1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
        end
        check({name, "_latency"}, lat, exp_lat);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        start(v);
        @(negedge clk);
        in_valid  = 1'b0;
        in_weight = $urandom;
        in_pos    = 27'($urandom);
        check({name, "_busy"}, int'(busy), 1);
        check({name, "_in_ready_busy"}, int'(in_ready), 0);
        wait_result(name, v.lat);
        check({name, "_x"}, int'(out_x), v.ex);
        check({name, "_y"}, int'(out_y), v.ey);
        check({name, "_z"}, int'(out_z), v.ez);
        check({name, "_err"}, int'(out_err), v.eerr);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({name, "_valid_drop"}, int'(out_valid), 0);
        check({name, "_idle"}, int'(busy), 0);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [QW-1:0] hx, hy, hz;
        logic          herr;
        int            d0;
        tbl[0] = '{8'd1,   8'd1,   8'd2,   P_STD,  'h04, 'h08, 0,    0, LAT_OK};
        tbl[1] = '{8'd0,   8'd0,   8'd0,   P_STD,  0,    0,    0,    1, LAT_ERR};
        tbl[2] = '{8'd1,   8'd1,   8'd1,   P_STD,  'h05, 'h05, 0,    0, LAT_OK};
        tbl[3] = '{8'd255, 8'd255, 8'd255, P_FULL, 'h70, 'h70, 'h70, 0, LAT_OK};
        tbl[4] = '{8'd0,   8'd0,   8'd5,   P_STD,  0,    'h10, 0,    0, LAT_OK};
        tbl[5] = '{8'd3,   8'd0,   8'd0,   P_STD,  0,    0,    0,    0, LAT_OK};
        tbl[6] = '{8'd0,   8'd7,   8'd0,   P_STD,  'h10, 0,    0,    0, LAT_OK};
        tbl[7] = '{8'd2,   8'd1,   8'd0,   P_STD,  'h05, 0,    0,    0, LAT_OK};

        #12;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_err", int'(out_err), 0);
        check("rst_out_xyz", int'({out_x, out_y, out_z}), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", int'(in_ready), 1);

        for (int i = 0; i < 8; i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // Backpressure with in_valid held high throughout
        d0 = deliveries;
        start(tbl[0]);
        wait_result("bp", LAT_OK);
        hx = out_x; hy = out_y; hz = out_z; herr = out_err;
        check("bp_x", int'(hx), 'h04);
        check("bp_y", int'(hy), 'h08);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_hold_valid", int'(out_valid), 1);
            check("bp_hold_in_ready", int'(in_ready), 0);
            check("bp_hold_out", int'({out_x, out_y, out_z, out_err}),
                  int'({hx, hy, hz, herr}));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_valid_drop", int'(out_valid), 0);
        check("bp_no_same_edge_xfer", int'(busy), 0);
        check("bp_one_result", deliveries - d0, 1);
        @(negedge clk);
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("bp_next_xfer", int'(busy), 1);
        @(negedge clk);
        in_valid = 1'b0;
        wait_result("bp2", LAT_OK);
        check("bp2_x", int'(out_x), 'h04);
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset pulse in the middle of DIVIDE
        start(tbl[2]);
        @(negedge clk);
        in_valid = 1'b0;
        for (int e = 2; e <= 6; e++) @(posedge clk);
        #1;
        watch = 1'b1;
        rst = 1'b1;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        check("midrst_out_valid", int'(out_valid), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        check("midrst_no_output", spurious, 0);
        watch = 1'b0;
        run_vec(tbl[0], "after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
